mips_decode_stage: RTL and testbench

Parametrised instruction-decode stage for the five-stage MIPS pipeline, sitting between the IF/ID latch and the execute stage. It decodes the opcode into control bits, reads two operands from an internal register file and sign-extends the immediate. It registers everything into the ID/EX pipeline latch. Unlike the earlier decode stage, it takes the full 32-bit instruction, supports addi, bypasses same-cycle write-back, detects load-use hazards, and accepts a flush.

---
 rtl/mips_decode_stage.sv | 181 ++++++++++++++++++
 tb/tb_mips_decode_stage.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_decode_stage.sv
// Instruction decode stage: control decode, 2R/1W register file with optional write-back
// bypass, load-use hazard detection and the ID/EX pipeline latch with bubble insertion.
module mips_decode_stage #(
   parameter int DATA_W    = 32,
   parameter int REG_COUNT = 32,
   parameter bit WB_BYPASS = 1'b1,
   localparam int AW       = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       id_instr,
   input  logic [DATA_W-1:0] id_npc,
   input  logic              wb_regwrite,
   input  logic [AW-1:0]     wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              flush,
   output logic              stall,
   output logic [1:0]        ex_ctlwb_out,
   output logic [2:0]        ex_ctlm_out,
   output logic              ex_regdst,
   output logic              ex_alusrc,
   output logic [1:0]        ex_aluop,
   output logic [DATA_W-1:0] ex_npc,
   output logic [DATA_W-1:0] ex_a,
   output logic [DATA_W-1:0] ex_b,
   output logic [DATA_W-1:0] ex_imm,
   output logic [5:0]        ex_funct,
   output logic [AW-1:0]     ex_rs,
   output logic [AW-1:0]     ex_rt,
   output logic [AW-1:0]     ex_rd
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   logic [5:0]        opcode;
   logic [AW-1:0]     rs_idx;
   logic [AW-1:0]     rt_idx;
   logic [AW-1:0]     rd_idx;
   logic [DATA_W-1:0] imm_ext;

   assign opcode  = id_instr[31:26];
   assign rs_idx  = id_instr[21 +: AW];
   assign rt_idx  = id_instr[16 +: AW];
   assign rd_idx  = id_instr[11 +: AW];
   assign imm_ext = DATA_W'($signed(id_instr[15:0]));

   logic       dec_regdst;
   logic       dec_alusrc;
   logic       dec_memtoreg;
   logic       dec_regwrite;
   logic       dec_memread;
   logic       dec_memwrite;
   logic       dec_branch;
   logic [1:0] dec_aluop;
   logic       uses_rt;

   always_comb begin
      dec_regdst   = 1'b0;
      dec_alusrc   = 1'b0;
      dec_memtoreg = 1'b0;
      dec_regwrite = 1'b0;
      dec_memread  = 1'b0;
      dec_memwrite = 1'b0;
      dec_branch   = 1'b0;
      dec_aluop    = 2'b00;
      uses_rt      = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            dec_regdst   = 1'b1;
            dec_regwrite = 1'b1;
            dec_aluop    = 2'b10;
            uses_rt      = 1'b1;
         end
         OP_LW: begin
            dec_alusrc   = 1'b1;
            dec_memtoreg = 1'b1;
            dec_regwrite = 1'b1;
            dec_memread  = 1'b1;
         end
         OP_SW: begin
            dec_alusrc   = 1'b1;
            dec_memwrite = 1'b1;
            uses_rt      = 1'b1;
         end
         OP_BEQ: begin
            dec_branch   = 1'b1;
            dec_aluop    = 2'b01;
            uses_rt      = 1'b1;
         end
         OP_ADDI: begin
            dec_alusrc   = 1'b1;
            dec_regwrite = 1'b1;
         end
         default: ;
      endcase
   end

   logic [DATA_W-1:0] rf [REG_COUNT];
   logic              wb_write;
   logic [DATA_W-1:0] rd_data_a;
   logic [DATA_W-1:0] rd_data_b;

   assign wb_write = wb_regwrite && (wb_rd != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < REG_COUNT; i++) rf[i] <= '0;
      end else if (wb_write) begin
         rf[wb_rd] <= wb_data;
      end
   end

   // r0 is hardwired; bypass only when enabled and the same register is being written
   always_comb begin
      if (rs_idx == '0)
         rd_data_a = '0;
      else if (WB_BYPASS && wb_write && (wb_rd == rs_idx))
         rd_data_a = wb_data;
      else
         rd_data_a = rf[rs_idx];

      if (rt_idx == '0)
         rd_data_b = '0;
      else if (WB_BYPASS && wb_write && (wb_rd == rt_idx))
         rd_data_b = wb_data;
      else
         rd_data_b = rf[rt_idx];
   end

   logic bubble;

   assign stall  = ex_ctlm_out[1] && (ex_rt != '0) &&
                   ((ex_rt == rs_idx) || (uses_rt && (ex_rt == rt_idx)));
   assign bubble = stall || flush;

   // Data fields load even during a bubble; only the control bits are squashed
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_ctlwb_out <= '0;
         ex_ctlm_out  <= '0;
         ex_regdst    <= 1'b0;
         ex_alusrc    <= 1'b0;
         ex_aluop     <= '0;
         ex_npc       <= '0;
         ex_a         <= '0;
         ex_b         <= '0;
         ex_imm       <= '0;
         ex_funct     <= '0;
         ex_rs        <= '0;
         ex_rt        <= '0;
         ex_rd        <= '0;
      end else begin
         if (bubble) begin
            ex_ctlwb_out <= '0;
            ex_ctlm_out  <= '0;
            ex_regdst    <= 1'b0;
            ex_alusrc    <= 1'b0;
            ex_aluop     <= '0;
         end else begin
            ex_ctlwb_out <= {dec_regwrite, dec_memtoreg};
            ex_ctlm_out  <= {dec_branch, dec_memread, dec_memwrite};
            ex_regdst    <= dec_regdst;
            ex_alusrc    <= dec_alusrc;
            ex_aluop     <= dec_aluop;
         end
         ex_npc   <= id_npc;
         ex_a     <= rd_data_a;
         ex_b     <= rd_data_b;
         ex_imm   <= imm_ext;
         ex_funct <= id_instr[5:0];
         ex_rs    <= rs_idx;
         ex_rt    <= rt_idx;
         ex_rd    <= rd_idx;
      end
   end

endmodule

// File: tb/tb_mips_decode_stage.sv
// Bench for mips_decode_stage: two configurations (32-bit/32 regs/bypass, 16-bit/8 regs/no bypass)
// driven with shared stimulus and checked every cycle against a behavioural model.
module tb_mips_decode_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] id_instr = '0;
   logic [31:0] id_npc = '0;
   logic        wb_regwrite = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic [31:0] wb_data = '0;
   logic        flush = 1'b0;

   always #5 clk = ~clk;

   logic        a_stall, a_regdst, a_alusrc;
   logic [1:0]  a_ctlwb, a_aluop;
   logic [2:0]  a_ctlm;
   logic [31:0] a_npc, a_a, a_b, a_imm;
   logic [5:0]  a_funct;
   logic [4:0]  a_rs, a_rt, a_rd;

   logic        b_stall, b_regdst, b_alusrc;
   logic [1:0]  b_ctlwb, b_aluop;
   logic [2:0]  b_ctlm;
   logic [15:0] b_npc, b_a, b_b, b_imm;
   logic [5:0]  b_funct;
   logic [2:0]  b_rs, b_rt, b_rd;

   mips_decode_stage #(.DATA_W(32), .REG_COUNT(32), .WB_BYPASS(1'b1)) dut_a (
      .clk(clk), .reset(reset), .id_instr(id_instr), .id_npc(id_npc),
      .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
      .stall(a_stall), .ex_ctlwb_out(a_ctlwb), .ex_ctlm_out(a_ctlm),
      .ex_regdst(a_regdst), .ex_alusrc(a_alusrc), .ex_aluop(a_aluop),
      .ex_npc(a_npc), .ex_a(a_a), .ex_b(a_b), .ex_imm(a_imm),
      .ex_funct(a_funct), .ex_rs(a_rs), .ex_rt(a_rt), .ex_rd(a_rd));

   mips_decode_stage #(.DATA_W(16), .REG_COUNT(8), .WB_BYPASS(1'b0)) dut_b (
      .clk(clk), .reset(reset), .id_instr(id_instr), .id_npc(id_npc[15:0]),
      .wb_regwrite(wb_regwrite), .wb_rd(wb_rd[2:0]), .wb_data(wb_data[15:0]), .flush(flush),
      .stall(b_stall), .ex_ctlwb_out(b_ctlwb), .ex_ctlm_out(b_ctlm),
      .ex_regdst(b_regdst), .ex_alusrc(b_alusrc), .ex_aluop(b_aluop),
      .ex_npc(b_npc), .ex_a(b_a), .ex_b(b_b), .ex_imm(b_imm),
      .ex_funct(b_funct), .ex_rs(b_rs), .ex_rt(b_rt), .ex_rd(b_rd));

   logic [8:0] a_ctl, b_ctl;
   assign a_ctl = {a_ctlwb, a_ctlm, a_regdst, a_alusrc, a_aluop};
   assign b_ctl = {b_ctlwb, b_ctlm, b_regdst, b_alusrc, b_aluop};

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // ctl packing: {regwrite, memtoreg, branch, memread, memwrite, regdst, alusrc, aluop[1:0]}
   typedef struct packed {
      logic [8:0]  ctl;
      logic [31:0] npc, a, b, imm;
      logic [5:0]  funct;
      logic [4:0]  rs, rt, rd;
   } ex_t;

   ex_t         mex [2];
   logic [31:0] mrf [2][32];

   function automatic logic [31:0] dmask(int c);
      return (c == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
   endfunction

   function automatic logic [4:0] amask(int c);
      return (c == 0) ? 5'd31 : 5'd7;
   endfunction

   function automatic logic [8:0] ctl_of(logic [5:0] op);
      case (op)
         6'h00:   return 9'b10_000_1_0_10;
         6'h23:   return 9'b11_010_0_1_00;
         6'h2B:   return 9'b00_001_0_1_00;
         6'h04:   return 9'b00_100_0_0_01;
         6'h08:   return 9'b10_000_0_1_00;
         default: return 9'b0;
      endcase
   endfunction

   function automatic logic [31:0] mread(int c, logic [4:0] r);
      logic [4:0] w;
      w = wb_rd & amask(c);
      if (r == 0) return 32'h0;
      if (c == 0 && wb_regwrite && w != 0 && w == r) return wb_data & dmask(c);
      return mrf[c][r];
   endfunction

   function automatic logic model_stall(int c);
      logic [5:0] op;
      logic [4:0] rs, rt;
      logic       uses_rt;
      op      = id_instr[31:26];
      rs      = id_instr[25:21] & amask(c);
      rt      = id_instr[20:16] & amask(c);
      uses_rt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
      return mex[c].ctl[5] && (mex[c].rt != 0) && ((mex[c].rt == rs) || (uses_rt && mex[c].rt == rt));
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < 2; c++) begin
            mex[c] = '0;
            for (int r = 0; r < 32; r++) mrf[c][r] = '0;
         end
      end else begin
         for (int c = 0; c < 2; c++) begin
            ex_t        n;
            logic [4:0] w;
            n       = '0;
            n.ctl   = (model_stall(c) || flush) ? 9'b0 : ctl_of(id_instr[31:26]);
            n.npc   = id_npc & dmask(c);
            n.rs    = id_instr[25:21] & amask(c);
            n.rt    = id_instr[20:16] & amask(c);
            n.rd    = id_instr[15:11] & amask(c);
            n.a     = mread(c, n.rs);
            n.b     = mread(c, n.rt);
            n.imm   = {{16{id_instr[15]}}, id_instr[15:0]} & dmask(c);
            n.funct = id_instr[5:0];
            w       = wb_rd & amask(c);
            if (wb_regwrite && w != 0) mrf[c][w] = wb_data & dmask(c);
            mex[c] = n;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      check("a_ctl",   a_ctl, mex[0].ctl);
      check("a_npc",   a_npc, mex[0].npc);
      check("a_a",     a_a, mex[0].a);
      check("a_b",     a_b, mex[0].b);
      check("a_imm",   a_imm, mex[0].imm);
      check("a_idx",   {a_funct, a_rs, a_rt, a_rd}, {mex[0].funct, mex[0].rs, mex[0].rt, mex[0].rd});
      check("a_stall", a_stall, model_stall(0));
      check("b_ctl",   b_ctl, mex[1].ctl);
      check("b_npc",   b_npc, mex[1].npc);
      check("b_a",     b_a, mex[1].a);
      check("b_b",     b_b, mex[1].b);
      check("b_imm",   b_imm, mex[1].imm);
      check("b_idx",   {b_funct, b_rs, b_rt, b_rd},
            {mex[1].funct, mex[1].rs[2:0], mex[1].rt[2:0], mex[1].rd[2:0]});
      check("b_stall", b_stall, model_stall(1));
   end

   // ---------------- stimulus ----------------
   localparam logic [31:0] NOP = 32'hFC00_0000;

   task automatic set_in(input logic [31:0] ins, input logic we, input logic [4:0] rd,
                         input logic [31:0] d, input logic fl);
      id_instr    = ins;
      wb_regwrite = we;
      wb_rd       = rd;
      wb_data     = d;
      flush       = fl;
      id_npc      = $urandom();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] r32;
      logic [5:0]  op;
      logic [4:0]  rs, rt;
      logic [31:0] ins;

      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check("rst_a_ctl", a_ctl, 9'b0);
      check("rst_a_a", a_a, 32'h0);
      check("rst_a_stall", a_stall, 1'b0);

      set_in(NOP, 1'b1, 5'd4, 32'h64, 1'b0);   tick();
      set_in(NOP, 1'b1, 5'd5, 32'h0A, 1'b0);   tick();
      set_in(NOP, 1'b1, 5'd2, 32'h1111, 1'b0); tick();
      set_in(32'h00A4_1020, 1'b0, 5'd0, 32'h0, 1'b0); tick();
      check("rtype_a", a_a, 32'h0A);
      check("rtype_b", a_b, 32'h64);
      check("rtype_ctlwb", a_ctlwb, 2'b10);
      check("rtype_ctlm", a_ctlm, 3'b000);
      check("rtype_aluop", a_aluop, 2'b10);
      check("rtype_regdst", a_regdst, 1'b1);
      check("rtype_rd", a_rd, 5'd2);
      check("rtype_b_a16", b_a, 16'h0A);

      set_in(32'h8C82_0002, 1'b0, 5'd0, 32'h0, 1'b0); tick();
      check("lw_ctlm", a_ctlm, 3'b010);
      set_in(32'h0042_1020, 1'b0, 5'd0, 32'h0, 1'b0);
      #1;
      check("lu_stall_a", a_stall, 1'b1);
      check("lu_stall_b", b_stall, 1'b1);
      tick();
      check("lu_bubble", a_ctl, 9'b0);
      check("lu_stall_drop", a_stall, 1'b0);
      tick();
      check("lu_add_ctlwb", a_ctlwb, 2'b10);
      check("lu_add_ctlm", a_ctlm, 3'b000);

      set_in(32'h2043_0005, 1'b1, 5'd2, 32'hDEAD, 1'b0); tick();
      check("byp_a", a_a, 32'hDEAD);
      check("nobyp_b", b_a, 16'h1111);
      check("addi_alusrc", b_alusrc, 1'b1);
      check("addi_ctlwb", b_ctlwb, 2'b10);
      check("addi_imm", b_imm, 16'h0005);

      set_in(NOP, 1'b1, 5'd0, 32'hFFFF, 1'b0); tick();
      set_in(32'h0000_1020, 1'b0, 5'd0, 32'h0, 1'b0); tick();
      check("r0_a", a_a, 32'h0);
      check("r0_b16", b_a, 16'h0);

      set_in(32'h1000_0008, 1'b0, 5'd0, 32'h0, 1'b1); tick();
      check("flush_ctlm", a_ctlm, 3'b000);
      check("flush_aluop", a_aluop, 2'b00);
      check("flush_imm", a_imm, 32'h8);
      set_in(32'h1000_0008, 1'b0, 5'd0, 32'h0, 1'b0); tick();
      check("beq_ctlm", a_ctlm, 3'b100);
      check("beq_aluop", a_aluop, 2'b01);

      set_in(32'h2000_FFFE, 1'b0, 5'd0, 32'h0, 1'b0); tick();
      check("imm16_neg", b_imm, 16'hFFFE);
      check("imm32_neg", a_imm, 32'hFFFF_FFFE);

      set_in(32'h8C82_0002, 1'b0, 5'd0, 32'h0, 1'b0); tick();
      set_in(32'h0042_1020, 1'b0, 5'd0, 32'h0, 1'b0);
      #1;
      check("pre_rst_stall", a_stall, 1'b1);
      reset = 1'b1;
      #1;
      check("mrst_a_ctl", a_ctl, 9'b0);
      check("mrst_a_npc", a_npc, 32'h0);
      check("mrst_a_a", a_a, 32'h0);
      check("mrst_a_b", a_b, 32'h0);
      check("mrst_a_imm", a_imm, 32'h0);
      check("mrst_a_idx", {a_funct, a_rs, a_rt, a_rd}, 21'h0);
      check("mrst_a_stall", a_stall, 1'b0);
      check("mrst_b_ctl", b_ctl, 9'b0);
      @(posedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < 2000; i++) begin
         if (model_stall(0)) begin
            ins = id_instr;
         end else begin
            case ($urandom_range(0, 5))
               0:       op = 6'h00;
               1:       op = 6'h23;
               2:       op = 6'h2B;
               3:       op = 6'h04;
               4:       op = 6'h08;
               default: op = 6'($urandom_range(0, 63));
            endcase
            rs  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            rt  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            r32 = $urandom();
            ins = {op, rs, rt, r32[15:0]};
         end
         r32 = $urandom();
         set_in(ins, r32[0] | r32[1], ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)),
                $urandom(), ($urandom_range(0, 7) == 0));
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
